// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle control path: FSM state encoding,
// opcode values, datapath mux selects and the decoded control vector.
package ctrl_pkg;

  localparam logic [1:0] OP_DP   = 2'b00;
  localparam logic [1:0] OP_MEM  = 2'b01;
  localparam logic [1:0] OP_BR   = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  localparam logic [1:0] SRCA_REG    = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_R  = 4'd2,
    S_EXEC_I  = 4'd3,
    S_ALU_WB  = 4'd4,
    S_MEM_ADR = 4'd5,
    S_MEM_RD  = 4'd6,
    S_MEM_WB  = 4'd7,
    S_MEM_WR  = 4'd8,
    S_BRANCH  = 4'd9,
    S_HALT    = 4'd10
  } state_t;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
    logic       flag_update;
    logic       reg_w;
    logic       mem_w_raw;
    logic       pcs;
    logic       halted;
  } ctrl_out_t;

  // True in the last cycle of an instruction, i.e. when the next state is FETCH.
  function automatic logic is_retire(input state_t s, input logic mem_ready);
    logic r;
    case (s)
      S_ALU_WB, S_MEM_WB, S_BRANCH: r = 1'b1;
      S_MEM_WR:                     r = mem_ready;
      default:                      r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ctrl_out_dec.sv
// Purely combinational state-to-control-vector decoder. The fetch handshake
// enables are qualified by mem_ready in the parent.
module ctrl_out_dec
  import ctrl_pkg::*;
(
  input  state_t    i_state,
  input  logic      i_s_flag,
  output ctrl_out_t o_ctrl
);

  always_comb begin
    o_ctrl            = '0;
    o_ctrl.alu_src_a  = SRCA_PC;
    o_ctrl.alu_src_b  = SRCB_FOUR;
    o_ctrl.result_src = RES_ALU;
    case (i_state)
      S_FETCH: begin
        o_ctrl.ir_write = 1'b1;
        o_ctrl.pc_write = 1'b1;
      end
      S_DECODE: begin
        o_ctrl.alu_src_a = SRCA_PC;
        o_ctrl.alu_src_b = SRCB_FOUR;
      end
      S_EXEC_R: begin
        o_ctrl.alu_src_a   = SRCA_REG;
        o_ctrl.alu_src_b   = SRCB_REG;
        o_ctrl.alu_op      = 1'b1;
        o_ctrl.flag_update = i_s_flag;
      end
      S_EXEC_I: begin
        o_ctrl.alu_src_a   = SRCA_REG;
        o_ctrl.alu_src_b   = SRCB_IMM;
        o_ctrl.alu_op      = 1'b1;
        o_ctrl.flag_update = i_s_flag;
      end
      S_ALU_WB: begin
        o_ctrl.result_src = RES_ALUOUT;
        o_ctrl.reg_w      = 1'b1;
      end
      S_MEM_ADR: begin
        o_ctrl.alu_src_a = SRCA_REG;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = 1'b0;
      end
      S_MEM_RD: begin
        o_ctrl.adr_src = 1'b1;
      end
      S_MEM_WB: begin
        o_ctrl.result_src = RES_RDATA;
        o_ctrl.reg_w      = 1'b1;
      end
      S_MEM_WR: begin
        o_ctrl.adr_src   = 1'b1;
        o_ctrl.mem_w_raw = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a  = SRCA_ALUOUT;
        o_ctrl.alu_src_b  = SRCB_IMM;
        o_ctrl.result_src = RES_ALU;
        o_ctrl.pcs        = 1'b1;
      end
      S_HALT: begin
        o_ctrl.halted = 1'b1;
      end
      default: begin
        o_ctrl.halted = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the ASIP core (fetch/decode/execute/memory/writeback).
// Define MULTICYCLE_CTRL_PERF_EN to add cycle_cnt/instr_cnt performance counters.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int OP_W    = 2,
  parameter int FUNCT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               mem_ready,
  output logic               ir_write,
  output logic               pc_write,
  output logic               adr_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         result_src,
  output logic               alu_op,
  output logic               flag_update,
  output logic               reg_w,
  output logic               mem_w_raw,
  output logic               pcs,
  output logic               halted
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        instr_cnt
`endif
);

  state_t    r_state;
  state_t    w_next_state;
  logic      r_s_flag;
  logic      w_s_flag_next;
  ctrl_out_t w_ctrl;
  logic      w_unused_funct;

  assign w_unused_funct = ^funct[FUNCT_W-2:1];

  // State register; S bit is latched in DECODE so flag_update stays a pure state decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_FETCH;
      r_s_flag <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_s_flag <= w_s_flag_next;
    end
  end

  always_comb begin
    w_next_state  = S_FETCH;
    w_s_flag_next = r_s_flag;
    case (r_state)
      S_FETCH: begin
        if (mem_ready) w_next_state = S_DECODE;
        else           w_next_state = S_FETCH;
      end
      S_DECODE: begin
        w_s_flag_next = funct[0];
        case (op)
          OP_DP: begin
            if (funct[FUNCT_W-1]) w_next_state = S_EXEC_I;
            else                  w_next_state = S_EXEC_R;
          end
          OP_MEM:  w_next_state = S_MEM_ADR;
          OP_BR:   w_next_state = S_BRANCH;
          OP_HALT: w_next_state = S_HALT;
          default: w_next_state = S_FETCH;
        endcase
      end
      S_EXEC_R, S_EXEC_I: w_next_state = S_ALU_WB;
      S_ALU_WB:           w_next_state = S_FETCH;
      S_MEM_ADR: begin
        if (funct[0]) w_next_state = S_MEM_RD;
        else          w_next_state = S_MEM_WR;
      end
      S_MEM_RD: begin
        if (mem_ready) w_next_state = S_MEM_WB;
        else           w_next_state = S_MEM_RD;
      end
      S_MEM_WB: w_next_state = S_FETCH;
      S_MEM_WR: begin
        if (mem_ready) w_next_state = S_FETCH;
        else           w_next_state = S_MEM_WR;
      end
      S_BRANCH: w_next_state = S_FETCH;
      S_HALT:   w_next_state = S_HALT;
      default:  w_next_state = S_FETCH;
    endcase
  end

  ctrl_out_dec u_out_dec (
    .i_state  (r_state),
    .i_s_flag (r_s_flag),
    .o_ctrl   (w_ctrl)
  );

  // Fetch handshake is the only input-dependent term; forced low during reset.
  assign ir_write    = w_ctrl.ir_write & mem_ready & ~reset;
  assign pc_write    = w_ctrl.pc_write & mem_ready & ~reset;
  assign adr_src     = w_ctrl.adr_src;
  assign alu_src_a   = w_ctrl.alu_src_a;
  assign alu_src_b   = w_ctrl.alu_src_b;
  assign result_src  = w_ctrl.result_src;
  assign alu_op      = w_ctrl.alu_op;
  assign flag_update = w_ctrl.flag_update;
  assign reg_w       = w_ctrl.reg_w;
  assign mem_w_raw   = w_ctrl.mem_w_raw;
  assign pcs         = w_ctrl.pcs;
  assign halted      = w_ctrl.halted;

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instr_cnt;

  // Performance counters; both wrap naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycle_cnt <= 32'd0;
      r_instr_cnt <= 32'd0;
    end else begin
      if (r_state != S_HALT) r_cycle_cnt <= r_cycle_cnt + 32'd1;
      else                   r_cycle_cnt <= r_cycle_cnt;
      if (is_retire(r_state, mem_ready)) r_instr_cnt <= r_instr_cnt + 32'd1;
      else                               r_instr_cnt <= r_instr_cnt;
    end
  end

  assign cycle_cnt = r_cycle_cnt;
  assign instr_cnt = r_instr_cnt;
`endif

endmodule
